// File: rtl/slow_frame_receiver_if.sv
// Bundle between the CDR byte stream, the frame receiver and its consumer.
// Inputs are qualified by word_tick_i alone; outputs are registered pulses and levels.
interface slow_frame_receiver_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 word_tick_i;
    logic [7:0]           data_i;
    logic                 comma_i;
    logic                 error_i;
    logic [127:0]         payload_o;
    logic                 frame_tick_o;
    logic                 frame_error_o;
    logic                 locked_o;
    logic [ERR_CNT_W-1:0] err_count_o;
    logic [1:0]           dbg_state_o;

    modport master (
        output word_tick_i, data_i, comma_i, error_i,
        input  payload_o, frame_tick_o, frame_error_o, locked_o, err_count_o, dbg_state_o
    );

    modport slave (
        input  word_tick_i, data_i, comma_i, error_i,
        output payload_o, frame_tick_o, frame_error_o, locked_o, err_count_o, dbg_state_o
    );
endinterface

// File: rtl/slow_frame_receiver.sv
// Reassembles comma + 16 data bytes + XOR checksum frames from the decoded CDR stream,
// publishes good payloads, and tracks framing errors and link lock.
module slow_frame_receiver #(
    parameter int BYTE_TIMEOUT = 8192,
    parameter int LOCK_FRAMES  = 4,
    parameter int ERR_CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    slow_frame_receiver_if.slave bus
);
    localparam int TO_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int LK_W = $clog2(LOCK_FRAMES + 1);

    typedef logic [127:0] payload_t;
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_idx;
    logic [7:0]           r_xor;
    payload_t             r_buf;
    payload_t             r_payload;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_frame_tick;
    logic                 r_frame_error;
    logic                 r_locked;
    logic [LK_W-1:0]      r_good_cnt;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic w_tick;
    logic w_timeout;
    logic w_good;
    logic w_bad;

    // A word tick on the edge where the idle count would reach BYTE_TIMEOUT wins over the timeout.
    assign w_tick    = bus.word_tick_i;
    assign w_timeout = (r_state != HUNT) && !w_tick && (r_to_cnt == TO_W'(BYTE_TIMEOUT - 1));
    assign w_good    = w_tick && (r_state == CHECK) && !bus.error_i && !bus.comma_i
                       && (bus.data_i == r_xor);
    assign w_bad     = w_timeout
                       || (w_tick && (((r_state == DATA) && (bus.error_i || bus.comma_i))
                                      || ((r_state == CHECK) && !w_good)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= HUNT;
            r_idx         <= '0;
            r_xor         <= '0;
            r_buf         <= '0;
            r_payload     <= '0;
            r_to_cnt      <= '0;
            r_frame_tick  <= 1'b0;
            r_frame_error <= 1'b0;
            r_locked      <= 1'b0;
            r_good_cnt    <= '0;
            r_err_count   <= '0;
        end else begin
            r_frame_tick  <= w_good;
            r_frame_error <= w_bad;

            if (w_good) begin
                r_payload <= r_buf;
            end

            if (w_bad) begin
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (w_good && (r_good_cnt != LK_W'(LOCK_FRAMES))) begin
                r_good_cnt <= r_good_cnt + 1'b1;
                r_locked   <= (r_good_cnt == LK_W'(LOCK_FRAMES - 1));
            end

            if (w_bad && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if ((r_state == HUNT) || w_tick || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            case (r_state)
                HUNT: begin
                    if (w_tick && bus.comma_i && !bus.error_i) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                        r_xor   <= '0;
                    end
                end
                DATA: begin
                    if (w_timeout) begin
                        r_state <= HUNT;
                    end else if (w_tick) begin
                        if (bus.error_i) begin
                            r_state <= HUNT;
                        end else if (bus.comma_i) begin
                            r_idx <= '0;
                            r_xor <= '0;
                        end else begin
                            r_buf[{r_idx, 3'b000} +: 8] <= bus.data_i;
                            r_xor <= r_xor ^ bus.data_i;
                            r_idx <= r_idx + 1'b1;
                            if (r_idx == 4'd15) begin
                                r_state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    // An unerrored comma here opens the next frame straight away.
                    if (w_timeout) begin
                        r_state <= HUNT;
                    end else if (w_tick) begin
                        if (bus.comma_i && !bus.error_i) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                            r_xor   <= '0;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign bus.payload_o     = r_payload;
    assign bus.frame_tick_o  = r_frame_tick;
    assign bus.frame_error_o = r_frame_error;
    assign bus.locked_o      = r_locked;
    assign bus.err_count_o   = r_err_count;
    assign bus.dbg_state_o   = r_state;
endmodule

// File: doc/slow_frame_receiver.md
Name: slow_frame_receiver

Overview:
- Receive-side framer for the slow serial link.
- Sits after CDR_10b_8b and consumes its decoded byte stream (word tick, data, comma, error).
- Reassembles the 128-bit payload_t frames that SlowTransmitter2 produces, and checks each frame with its checksum.
- Presents each good payload with a single-cycle frame tick, and reports framing errors and link lock status.

Parameters:
- BYTE_TIMEOUT, 8192: maximum clk cycles allowed between word ticks inside a frame. This is more than 2 word periods at 312.5 MHz with bit divider 313.
- LOCK_FRAMES, 4: number of consecutive good frames required before locked_o is asserted.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- word_tick_i, input, 1: single-cycle strobe from the CDR; a decoded symbol is valid on this cycle.
- data_i, input, 8: decoded byte. Valid only when word_tick_i is high.
- comma_i, input, 1: the symbol is the K28.5 comma. Valid only when word_tick_i is high.
- error_i, input, 1: 8b/10b code or disparity error on the symbol. Valid only when word_tick_i is high.
- payload_o, output, 128 (payload_t): last good payload. Holds its value between frames.
- frame_tick_o, output, 1: single-cycle pulse; a new payload_o is valid.
- frame_error_o, output, 1: single-cycle pulse; the current frame was aborted or rejected.
- locked_o, output, 1: high after LOCK_FRAMES consecutive good frames.
- err_count_o, output, ERR_CNT_W: saturating count of frame_error_o pulses.

Behaviour:
- Frame format: 1 comma, then 16 data bytes, then 1 checksum byte. The checksum is the XOR of the 16 data bytes.
- Byte k (k = 0..15, counted from the comma) maps to payload[8k+7:8k].
- Reset (asynchronous, active-high): state = HUNT, byte index = 0, timeout counter = 0, payload_o = 0, frame_tick_o = 0, frame_error_o = 0, locked_o = 0, err_count_o = 0, good-frame counter = 0.
- Reset mid-frame discards all partial data. No frame_error_o pulse is produced.
- Only cycles with word_tick_i high advance the state machine. data_i, comma_i and error_i are ignored on all other cycles.
- State machine:
  - HUNT: on tick with comma_i=1 and error_i=0, go to DATA with index = 0 and running XOR = 0. All other ticks are ignored and produce no error.
  - DATA:
    - tick with error_i=1: frame_error_o, go to HUNT.
    - tick with comma_i=1: frame_error_o, restart DATA at index 0. The comma is treated as the start of a new frame.
    - otherwise: store the byte at the current index, XOR it into the running checksum, increment the index. After index 15 is stored, go to CHECK.
  - CHECK:
    - tick with error_i=0, comma_i=0 and data_i equal to the running XOR: load the 16 stored bytes into payload_o and pulse frame_tick_o. Go to HUNT.
    - tick with comma_i=1: frame_error_o, go to DATA at index 0.
    - any other tick: frame_error_o, go to HUNT.
- Latency: frame_tick_o and the new payload_o appear on the clk cycle after the word tick that carried the checksum byte. They change in the same cycle.
- payload_o is never updated by a rejected frame. The partial-frame buffer is separate from payload_o.
- Timeout:
  - In DATA or CHECK, a counter counts cycles since the last word tick.
  - When it reaches BYTE_TIMEOUT: frame_error_o, go to HUNT.
  - If a word tick occurs in the same cycle the counter reaches BYTE_TIMEOUT, the word tick wins and the counter restarts at 0.
  - The counter is held at 0 while in HUNT.
- frame_tick_o and frame_error_o are mutually exclusive. At most one frame_error_o pulse occurs per word tick or timeout event.
- Lock:
  - Each frame_tick_o increments the good-frame counter, saturating at LOCK_FRAMES.
  - locked_o = 1 when the counter equals LOCK_FRAMES. It is updated in the same cycle as the frame_tick_o that completes the count.
  - Any frame_error_o clears the counter and locked_o in that same cycle.
- err_count_o increments on each frame_error_o and saturates at all-ones (no wrap-around).
- All outputs are registered.

Test Plan:
- Good frame: comma, bytes 0x00..0x0F, checksum 0x00 -> one frame_tick_o; payload_o = 0x0F0E0D0C_0B0A0908_07060504_03020100; frame_error_o stays 0.
- Lock: 4 good frames carrying 0xDEADBEEF x4 (checksum 0x00) -> locked_o rises with the 4th frame_tick_o. Then 1 frame with a bad checksum (0x01) -> frame_error_o pulse, locked_o = 0, err_count_o = 1, payload_o still 0xDEADBEEF x4.
- Comma at byte 7:
  - stimulus: comma, 7 data bytes, comma, then a full good frame body.
  - required: 1 frame_error_o; then frame_tick_o with the new payload, with no extra comma needed.
- error_i on byte 3 -> frame_error_o, state HUNT. Data ticks without a comma cause no output activity. The next comma-framed good frame is accepted.
- Timeout:
  - Stop word ticks after byte 5 -> frame_error_o exactly BYTE_TIMEOUT cycles after the last tick.
  - Variant: a tick arriving exactly on cycle BYTE_TIMEOUT -> no error, and the frame completes.
- Reset asserted asynchronously mid-DATA (between clock edges) -> all outputs 0 immediately. After release, a good frame is received normally.
- Saturation: with ERR_CNT_W=4, inject 20 bad frames -> err_count_o stops at 15.
